// File: rtl/mainmem_port_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mainmem_port_arbiter_pkg : widths, sizing and FSM encoding for the arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package mainmem_port_arbiter_pkg;

  localparam int MM_ADDR_W  = 14;
  localparam int MM_DATA_W  = 18;
  localparam int BANK_WORDS = 1024;
  localparam int MM_WORDS   = 11 * BANK_WORDS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mainmem_port_arbiter_rr_arb2.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mainmem_port_arbiter_rr_arb2 : two-way round-robin / fixed-priority pick
// with lock override; combinational pick, registered last winner.
// Rev 1.0
// ----------------------------------------------------------------------------
module mainmem_port_arbiter_rr_arb2 #(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       lock_ok_i,
  input  logic       grant_i,
  output logic       valid_o,
  output logic       id_o,
  output logic       hold_o
);

  logic last_q;

  always_comb begin
    valid_o = |req_i;
    id_o    = 1'b0;
    hold_o  = 1'b0;
    if (lock_ok_i && req_i[last_q]) begin
      id_o   = last_q;
      hold_o = 1'b1;
    end else if (req_i == 2'b10) begin
      id_o = 1'b1;
    end else if (req_i == 2'b11) begin
      id_o = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
    end
  end

  // Reset value 1 makes requester 0 the "not served last" side.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else if (grant_i) begin
      last_q <= id_o;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mainmem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mainmem_port_arbiter : shares one main-memory port between two requesters,
// one transaction in flight, with bounded lock and out-of-range trapping.
// Rev 1.0
// ----------------------------------------------------------------------------
module mainmem_port_arbiter
  import mainmem_port_arbiter_pkg::*;
#(
  parameter int ADDR       = MM_ADDR_W,
  parameter int DATA       = MM_DATA_W,
  parameter int MEM_WORDS  = MM_WORDS,
  parameter int FIXED_PRIO = 0,
  parameter int LOCK_MAX   = 4
) (
  input  logic            clka,
  input  logic            rst_n,
  input  logic            req0,
  input  logic            we0,
  input  logic [ADDR-1:0] addr0,
  input  logic [DATA-1:0] wdata0,
  input  logic            lock0,
  output logic            ack0,
  output logic [DATA-1:0] rdata0,
  output logic            err0,
  input  logic            req1,
  input  logic            we1,
  input  logic [ADDR-1:0] addr1,
  input  logic [DATA-1:0] wdata1,
  input  logic            lock1,
  output logic            ack1,
  output logic [DATA-1:0] rdata1,
  output logic            err1,
  output logic [ADDR-1:0] mem_addr,
  output logic            mem_we,
  output logic [DATA-1:0] mem_din,
  input  logic [DATA-1:0] mem_dout
);

  localparam int            CNT_W = $clog2(LOCK_MAX + 1);
  localparam logic [ADDR:0] LIMIT = (ADDR + 1)'(MEM_WORDS);

  state_t            state_q, state_d;
  logic              id_q, id_d;
  logic              oor_q, oor_d;
  logic              lock_held_q, lock_held_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA-1:0]   mem_din_q, mem_din_d;
  logic              mem_we_q, mem_we_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;
  logic              err0_q, err0_d, err1_q, err1_d;
  logic [DATA-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic              gnt_valid, gnt_id, gnt_hold, grant_en, lock_ok;
  logic [ADDR-1:0]   sel_addr;
  logic [DATA-1:0]   sel_din;
  logic              sel_we, sel_oor, cur_lock;

  assign lock_ok  = lock_held_q && (cnt_q < CNT_W'(LOCK_MAX));
  assign sel_addr = gnt_id ? addr1  : addr0;
  assign sel_din  = gnt_id ? wdata1 : wdata0;
  assign sel_we   = gnt_id ? we1    : we0;
  assign sel_oor  = {1'b0, sel_addr} >= LIMIT;
  assign cur_lock = id_q ? lock1 : lock0;

  mainmem_port_arbiter_rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .clk_i     (clka),
    .rst_ni    (rst_n),
    .req_i     ({req1, req0}),
    .lock_ok_i (lock_ok),
    .grant_i   (grant_en),
    .valid_o   (gnt_valid),
    .id_o      (gnt_id),
    .hold_o    (gnt_hold)
  );

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    oor_d       = oor_q;
    lock_held_d = lock_held_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_we_d    = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    err0_d      = 1'b0;
    err1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    grant_en    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          grant_en   = 1'b1;
          id_d       = gnt_id;
          mem_addr_d = sel_addr;
          mem_din_d  = sel_din;
          mem_we_d   = sel_we & ~sel_oor;
          oor_d      = sel_oor;
          cnt_d      = gnt_hold ? cnt_q + CNT_W'(1) : '0;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // Registered read data settles during WAIT; capture it into the response.
        if (id_q) begin
          ack1_d   = 1'b1;
          err1_d   = oor_q;
          rdata1_d = oor_q ? '0 : mem_dout;
        end else begin
          ack0_d   = 1'b1;
          err0_d   = oor_q;
          rdata0_d = oor_q ? '0 : mem_dout;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        lock_held_d = cur_lock;
        if (!cur_lock) cnt_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      id_q        <= 1'b0;
      oor_q       <= 1'b0;
      lock_held_q <= 1'b0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      oor_q       <= oor_d;
      lock_held_q <= lock_held_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
    end
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign err0     = err0_q;
  assign err1     = err1_q;
  assign rdata0   = rdata0_q;
  assign rdata1   = rdata1_q;
  assign mem_addr = mem_addr_q;
  assign mem_we   = mem_we_q;
  assign mem_din  = mem_din_q;

endmodule
`default_nettype wire

// File: tb/tb_mainmem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mainmem_port_arbiter : directed vectors, corner sequences and random
// traffic against a transaction-level reference of the arbiter and memory.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mainmem_port_arbiter;
  import mainmem_port_arbiter_pkg::*;

  localparam int AW    = 14;
  localparam int DW    = 18;
  localparam int DEPTH = 1 << AW;

  logic clka = 1'b0;
  always #5 clka = ~clka;

  logic          rst_n;
  logic          req0, we0, lock0, req1, we1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic          ack0, err0, ack1, err1, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;

  logic          ack0_b, err0_b, ack1_b, err1_b, mem_we_b;
  logic [DW-1:0] rdata0_b, rdata1_b, mem_din_b, mem_dout_b;
  logic [AW-1:0] mem_addr_b;

  mainmem_port_arbiter #(.FIXED_PRIO(0), .LOCK_MAX(4)) u_dut (
    .clka(clka), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .ack0(ack0), .rdata0(rdata0), .err0(err0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .ack1(ack1), .rdata1(rdata1), .err1(err1),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  mainmem_port_arbiter #(.FIXED_PRIO(1), .LOCK_MAX(4)) u_dut_fp (
    .clka(clka), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .lock0(lock0),
    .ack0(ack0_b), .rdata0(rdata0_b), .err0(err0_b),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .lock1(lock1),
    .ack1(ack1_b), .rdata1(rdata1_b), .err1(err1_b),
    .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_din(mem_din_b), .mem_dout(mem_dout_b)
  );

  // Memory models: 1-cycle registered read, read-first on a same-address write.
  logic [DW-1:0] mem_a [0:DEPTH-1];
  logic [DW-1:0] mem_b [0:DEPTH-1];
  logic          bd_clr, bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  always @(posedge clka) begin
    if (bd_clr) begin
      for (int i = 0; i < DEPTH; i++) mem_a[i] <= '0;
    end else if (bd_we) begin
      mem_a[bd_addr] <= bd_data;
    end else if (mem_we) begin
      mem_a[mem_addr] <= mem_din;
    end
    mem_dout <= mem_a[mem_addr];
  end

  always @(posedge clka) begin
    if (bd_clr) begin
      for (int i = 0; i < DEPTH; i++) mem_b[i] <= '0;
    end else if (mem_we_b) begin
      mem_b[mem_addr_b] <= mem_din_b;
    end
    mem_dout_b <= mem_b[mem_addr_b];
  end

  logic [DW-1:0] ref_mem [0:DEPTH-1];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clka);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clka);
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic pulse_reset();
    @(negedge clka);
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
    rst_n = 1'b0;
    @(negedge clka);
    rst_n = 1'b1;
  endtask

  // One isolated transaction; lat counts negedges from request to ack.
  task automatic do_txn(input bit id, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, output int lat,
                        output logic [DW-1:0] rd, output bit er,
                        output int wec, output bit aft);
    @(negedge clka);
    if (id) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd; lock1 = 1'b0; end
    else    begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd; lock0 = 1'b0; end
    lat = 0; rd = '0; er = 1'b0; wec = 0; aft = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clka);
      if (mem_we) wec++;
      if (id ? ack1 : ack0) begin
        lat = c;
        rd  = id ? rdata1 : rdata0;
        er  = id ? err1 : err0;
        break;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clka);
    aft = ack0 | ack1;
    if (lat != 0 && we && int'(a) < MM_WORDS) ref_mem[a] = wd;
  endtask

  task automatic new_op(input bit n);
    logic [AW-1:0] a;
    case ($urandom_range(0, 3))
      0:       a = AW'($urandom_range(0, 15));
      1:       a = AW'(14'h2BF8 + $urandom_range(0, 15));
      2:       a = AW'(14'h3FF0 + $urandom_range(0, 15));
      default: a = AW'($urandom_range(0, 7));
    endcase
    if (n) begin
      we1 = 1'($urandom_range(0, 1)); addr1 = a; wdata1 = DW'($urandom);
      lock1 = ($urandom_range(0, 2) == 0);
    end else begin
      we0 = 1'($urandom_range(0, 1)); addr0 = a; wdata0 = DW'($urandom);
      lock0 = ($urandom_range(0, 2) == 0);
    end
  endtask

  typedef struct {
    bit            id;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] exp_rd;
    bit            exp_err;
    int            exp_we;
  } vec_t;

  vec_t          vecs [8];
  int            lat, wec, na, nb0, nb1, last_cyc, m_cnt;
  logic [DW-1:0] rd, exp_rd;
  bit            er, aft, n, hold, exp_id, m_last, m_locked, oor, cur_we, cur_lock;
  bit   [1:0]    upd;
  logic [7:0]    seq;
  logic [AW-1:0] ca;
  logic [DW-1:0] cwd;

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; lock0 = 1'b0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; lock1 = 1'b0;
    bd_clr = 1'b0; bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    vecs[0] = '{1'b0, 1'b0, 14'h0401, 18'h00000, 18'h2ABCD, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b1, 14'h2BFF, 18'h3FFFF, 18'h01234, 1'b0, 1};
    vecs[2] = '{1'b1, 1'b0, 14'h2BFF, 18'h00000, 18'h3FFFF, 1'b0, 0};
    vecs[3] = '{1'b1, 1'b1, 14'h2C00, 18'h11111, 18'h00000, 1'b1, 0};
    vecs[4] = '{1'b0, 1'b0, 14'h2BFF, 18'h00000, 18'h3FFFF, 1'b0, 0};
    vecs[5] = '{1'b0, 1'b0, 14'h3FFF, 18'h00000, 18'h00000, 1'b1, 0};
    vecs[6] = '{1'b0, 1'b1, 14'h0000, 18'h2AAAA, 18'h00000, 1'b0, 1};
    vecs[7] = '{1'b1, 1'b0, 14'h0000, 18'h00000, 18'h2AAAA, 1'b0, 0};

    @(negedge clka); bd_clr = 1'b1;
    @(negedge clka); bd_clr = 1'b0;
    check("reset_ctl", 32'({ack0, ack1, err0, err1, mem_we}), 32'd0);
    check("reset_rdata0", 32'(rdata0), 32'd0);
    check("reset_rdata1", 32'(rdata1), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_mem_din", 32'(mem_din), 32'd0);

    bd_write(14'h0401, 18'h2ABCD);
    bd_write(14'h2BFF, 18'h01234);
    bd_write(14'h0005, 18'h15555);
    @(negedge clka); rst_n = 1'b1;

    // Reset while the write to 0x0005 is on the memory port.
    @(negedge clka);
    req0 = 1'b1; we0 = 1'b1; addr0 = 14'h0005; wdata0 = 18'h3FFFF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clka);
      if (mem_we) break;
    end
    check("abort_issue_seen", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_ctl_zero", 32'({ack0, ack1, err0, err1, mem_we}), 32'd0);
    check("abort_addr_zero", 32'(mem_addr), 32'd0);
    req0 = 1'b0;
    na = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clka);
      if (ack0 || ack1) na++;
    end
    check("abort_no_ack", 32'(na), 32'd0);
    rst_n = 1'b1;
    do_txn(1'b0, 1'b0, 14'h0005, 18'h0, lat, rd, er, wec, aft);
    check("abort_mem_kept", 32'(rd), 32'h15555);

    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i].id, vecs[i].we, vecs[i].addr, vecs[i].wd, lat, rd, er, wec, aft);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_we_cycles", i), 32'(wec), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d_ack_pulse", i), 32'(aft), 32'd0);
    end

    // Continuous contention, round-robin instance and fixed-priority instance.
    pulse_reset();
    @(negedge clka);
    req0 = 1'b1; we0 = 1'b0; addr0 = 14'h0401; lock0 = 1'b0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 14'h2BFF; lock1 = 1'b0;
    na = 0; nb0 = 0; nb1 = 0; seq = '0;
    for (int c = 0; c < 40 && na < 4; c++) begin
      @(negedge clka);
      if (ack0_b) nb0++;
      if (ack1_b) nb1++;
      if (ack0 || ack1) begin seq[na] = ack1; na++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("contend_rr_count", 32'(na), 32'd4);
    check("contend_rr_order", 32'(seq), 32'h0A);
    check("contend_fp_ack0", 32'(nb0), 32'd4);
    check("contend_fp_ack1", 32'(nb1), 32'd0);

    // Locked owner: initial grant plus LOCK_MAX held grants, then the other side.
    pulse_reset();
    @(negedge clka);
    req0 = 1'b1; we0 = 1'b0; addr0 = 14'h0401; lock0 = 1'b1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 14'h2BFF; lock1 = 1'b0;
    na = 0; seq = '0;
    for (int c = 0; c < 60 && na < 6; c++) begin
      @(negedge clka);
      if (ack0 || ack1) begin seq[na] = ack1; na++; end
    end
    req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0;
    check("lock_count", 32'(na), 32'd6);
    check("lock_order", 32'(seq), 32'h20);

    // Random traffic, both sides always requesting.
    pulse_reset();
    new_op(1'b0); new_op(1'b1);
    req0 = 1'b1; req1 = 1'b1;
    m_last = 1'b1; m_locked = 1'b0; m_cnt = 0; na = 0; last_cyc = -1; upd = 2'b00;
    for (int cyc = 0; cyc < 4000 && na < 200; cyc++) begin
      @(negedge clka);
      if (upd[0]) begin new_op(1'b0); upd[0] = 1'b0; end
      if (upd[1]) begin new_op(1'b1); upd[1] = 1'b0; end
      if (ack0 || ack1) begin
        n = ack1;
        check("rnd_single_ack", 32'(ack0 & ack1), 32'd0);
        hold   = m_locked && (m_cnt < 4);
        exp_id = hold ? m_last : ~m_last;
        check("rnd_winner", 32'(n), 32'(exp_id));
        ca       = n ? addr1  : addr0;
        cwd      = n ? wdata1 : wdata0;
        cur_we   = n ? we1    : we0;
        cur_lock = n ? lock1  : lock0;
        oor      = int'(ca) >= MM_WORDS;
        exp_rd   = oor ? '0 : ref_mem[ca];
        check("rnd_rdata", 32'(n ? rdata1 : rdata0), 32'(exp_rd));
        check("rnd_err", 32'(n ? err1 : err0), 32'(oor));
        if (last_cyc >= 0) check("rnd_gap", 32'(cyc - last_cyc), 32'd4);
        last_cyc = cyc;
        if (cur_we && !oor) ref_mem[ca] = cwd;
        m_cnt    = hold ? m_cnt + 1 : 0;
        m_last   = n;
        m_locked = cur_lock;
        if (!cur_lock) m_cnt = 0;
        upd[n] = 1'b1;
        na++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("rnd_txn_count", 32'(na), 32'd200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
